// File: rtl/addr_trans_pkg.sv
// Shared constants for the address translation stage: LoongArch ecodes, TLB page sizes
// and DMW CSR field positions, plus the direct-mapped-window hit test.
package trans_pkg;

   localparam logic [5:0] ECODE_NONE = 6'h00;
   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PIF  = 6'h03;
   localparam logic [5:0] ECODE_PME  = 6'h04;
   localparam logic [5:0] ECODE_PPI  = 6'h07;
   localparam logic [5:0] ECODE_ADE  = 6'h08;
   localparam logic [5:0] ECODE_TLBR = 6'h3F;

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_4M = 6'd22;

   localparam int DMW_PLV0_BIT = 0;
   localparam int DMW_PLV3_BIT = 3;
   localparam int DMW_MAT_LO   = 4;
   localparam int DMW_PSEG_LO  = 25;
   localparam int DMW_VSEG_LO  = 29;

   typedef enum logic [1:0] {
      MODE_DA,
      MODE_DMW,
      MODE_TLB
   } trans_mode_e;

   // PLV 1 and 2 have no enable bit in the DMW, so they can never hit a window.
   function automatic logic dmw_hit(input logic [31:0] dmw,
                                    input logic [31:0] vaddr,
                                    input logic [1:0]  plv);
      logic plv_ok;
      plv_ok = ((plv == 2'd0) && dmw[DMW_PLV0_BIT]) ||
               ((plv == 2'd3) && dmw[DMW_PLV3_BIT]);
      return plv_ok && (dmw[31:DMW_VSEG_LO] == vaddr[31:DMW_VSEG_LO]);
   endfunction

endpackage

// File: rtl/addr_trans_if.sv
// Request/response handshake bundle between the pipeline (master) and addr_trans (slave).
interface addr_trans_if #(parameter int PALEN = 32);

   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_vaddr;
   logic             req_store;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [PALEN-1:0] rsp_paddr;
   logic [1:0]       rsp_mat;
   logic             rsp_ex;
   logic [5:0]       rsp_ecode;
   logic [31:0]      rsp_badv;

   modport master (
      output req_valid, req_vaddr, req_store, rsp_ready,
      input  req_ready, rsp_valid, rsp_paddr, rsp_mat, rsp_ex, rsp_ecode, rsp_badv
   );

   modport slave (
      input  req_valid, req_vaddr, req_store, rsp_ready,
      output req_ready, rsp_valid, rsp_paddr, rsp_mat, rsp_ex, rsp_ecode, rsp_badv
   );

endinterface

// File: rtl/addr_trans_queue2.sv
// Two-entry FIFO with 1-bit wrapping head/tail pointers; flush empties it and
// overrides any push or pop in the same cycle.
module trans_queue2 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [1:0]       o_count
);

   logic [WIDTH-1:0] r_mem [2];
   logic [1:0]       r_count;
   logic             r_head;
   logic             r_tail;
   logic             w_push;
   logic             w_pop;

   assign w_push  = push && (r_count != 2'd2);
   assign w_pop   = pop && (r_count != 2'd0);
   assign o_data  = r_mem[r_head];
   assign o_count = r_count;

   // Storage is cleared on reset so the response data outputs start at zero.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_count  <= 2'd0;
         r_head   <= 1'b0;
         r_tail   <= 1'b0;
      end else if (flush) begin
         r_count <= 2'd0;
         r_head  <= 1'b0;
         r_tail  <= 1'b0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= i_data;
            r_tail        <= ~r_tail;
         end
         if (w_pop) begin
            r_head <= ~r_head;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

endmodule

// File: rtl/addr_trans.sv
// Virtual-to-physical translation stage (DA / DMW / TLB) feeding a 2-entry result queue.
// Optional macro ADDR_TRANS_STAT_EN adds the saturating stat_tlb_miss counter output.
module addr_trans
   import trans_pkg::*;
#(
   parameter bit IS_FETCH = 1'b0,
   parameter int PALEN    = 32
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        flush,
   addr_trans_if.slave bus,
   input  logic        crmd_da,
   input  logic        crmd_pg,
   input  logic [1:0]  crmd_plv,
   input  logic [1:0]  da_mat,
   input  logic [9:0]  asid,
   input  logic [31:0] dmw0,
   input  logic [31:0] dmw1,
   output logic [18:0] tlb_vppn,
   output logic        tlb_va_bit12,
   output logic [9:0]  tlb_asid,
   input  logic        tlb_found,
   input  logic        tlb_d,
   input  logic        tlb_v,
   input  logic [19:0] tlb_ppn,
   input  logic [5:0]  tlb_ps,
   input  logic [1:0]  tlb_plv,
   input  logic [1:0]  tlb_mat
`ifdef ADDR_TRANS_STAT_EN
   ,
   output logic [31:0] stat_tlb_miss
`endif
);

   localparam int EW = PALEN + 2 + 1 + 6 + 32;

   trans_mode_e      w_mode;
   logic [31:0]      w_paddr;
   logic [1:0]       w_mat;
   logic [5:0]       w_ecode;
   logic             w_ex;
   logic             w_accept;
   logic [1:0]       w_count;
   logic [EW-1:0]    w_entry_in;
   logic [EW-1:0]    w_entry_out;
   logic             w_unused;

   assign tlb_vppn     = bus.req_vaddr[31:13];
   assign tlb_va_bit12 = bus.req_vaddr[12];
   assign tlb_asid     = asid;

   assign bus.req_ready = (w_count != 2'd2) && !flush;
   assign bus.rsp_valid = (w_count != 2'd0);
   assign w_accept      = bus.req_valid && bus.req_ready;

   always_comb begin
      w_mode  = MODE_TLB;
      w_paddr = '0;
      w_mat   = tlb_mat;
      if (crmd_da) begin
         w_mode  = MODE_DA;
         w_paddr = bus.req_vaddr;
         w_mat   = da_mat;
      end else if (dmw_hit(dmw0, bus.req_vaddr, crmd_plv)) begin
         w_mode  = MODE_DMW;
         w_paddr = {dmw0[DMW_PSEG_LO+2:DMW_PSEG_LO], bus.req_vaddr[28:0]};
         w_mat   = dmw0[DMW_MAT_LO+1:DMW_MAT_LO];
      end else if (dmw_hit(dmw1, bus.req_vaddr, crmd_plv)) begin
         w_mode  = MODE_DMW;
         w_paddr = {dmw1[DMW_PSEG_LO+2:DMW_PSEG_LO], bus.req_vaddr[28:0]};
         w_mat   = dmw1[DMW_MAT_LO+1:DMW_MAT_LO];
      end else if (tlb_ps == PS_4M) begin
         w_paddr = {tlb_ppn[19:10], bus.req_vaddr[21:0]};
      end else begin
         w_paddr = {tlb_ppn, bus.req_vaddr[11:0]};
      end
   end

   // Only fetch misalignment can fault outside TLB mode; TLB faults are checked in priority order.
   always_comb begin
      w_ecode = ECODE_NONE;
      if (IS_FETCH && (bus.req_vaddr[1:0] != 2'b00)) begin
         w_ecode = ECODE_ADE;
      end else if (w_mode == MODE_TLB) begin
         if (!tlb_found) begin
            w_ecode = ECODE_TLBR;
         end else if (!tlb_v) begin
            w_ecode = IS_FETCH ? ECODE_PIF : (bus.req_store ? ECODE_PIS : ECODE_PIL);
         end else if (crmd_plv > tlb_plv) begin
            w_ecode = ECODE_PPI;
         end else if (bus.req_store && !tlb_d) begin
            w_ecode = ECODE_PME;
         end
      end
   end

   assign w_ex       = (w_ecode != ECODE_NONE);
   assign w_entry_in = {PALEN'(w_paddr), w_mat, w_ex, w_ecode, bus.req_vaddr};

   trans_queue2 #(
      .WIDTH (EW)
   ) u_queue (
      .clk     (clk),
      .resetn  (resetn),
      .flush   (flush),
      .push    (w_accept),
      .pop     (bus.rsp_ready),
      .i_data  (w_entry_in),
      .o_data  (w_entry_out),
      .o_count (w_count)
   );

   assign {bus.rsp_paddr, bus.rsp_mat, bus.rsp_ex, bus.rsp_ecode, bus.rsp_badv} = w_entry_out;

`ifdef ADDR_TRANS_STAT_EN
   logic [31:0] r_stat;

   // Counts refill exceptions at accept time; flush does not clear it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stat <= 32'd0;
      end else if (w_accept && (w_ecode == ECODE_TLBR) && (r_stat != 32'hFFFF_FFFF)) begin
         r_stat <= r_stat + 32'd1;
      end
   end

   assign stat_tlb_miss = r_stat;
`endif

   assign w_unused = ^{crmd_pg, dmw0[28], dmw0[24:6], dmw0[2:1],
                       dmw1[28], dmw1[24:6], dmw1[2:1]};

endmodule

// File: tb/tb_addr_trans.sv
// Bench for addr_trans: a load/store and a fetch instance share one stimulus stream and are
// compared against a queue-based reference model. Covers ADDR_TRANS_STAT_EN when defined.
module tb_addr_trans;

   typedef struct packed {
      logic [31:0] paddr;
      logic [1:0]  mat;
      logic        ex;
      logic [5:0]  ecode;
      logic [31:0] badv;
   } expT;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic        reqValid;
   logic [31:0] reqVaddr;
   logic        reqStore;
   logic        rspReady;
   logic        crmdDa;
   logic        crmdPg;
   logic [1:0]  crmdPlv;
   logic [1:0]  daMat;
   logic [9:0]  asid;
   logic [31:0] dmw0;
   logic [31:0] dmw1;
   logic        tlbFound;
   logic        tlbD;
   logic        tlbV;
   logic [19:0] tlbPpn;
   logic [5:0]  tlbPs;
   logic [1:0]  tlbPlv;
   logic [1:0]  tlbMat;

   logic [18:0] vppnLs, vppnIf;
   logic        bit12Ls, bit12If;
   logic [9:0]  asidLs, asidIf;

   expT qLs[$];
   expT qIf[$];
   int  total;
   int  bad;

`ifdef ADDR_TRANS_STAT_EN
   logic [31:0] statLs, statIf;
   int unsigned statLsModel, statIfModel;
`endif

   always #5 clk = ~clk;

   addr_trans_if #(.PALEN(32)) busLs();
   addr_trans_if #(.PALEN(32)) busIf();

   assign busLs.req_valid = reqValid;
   assign busLs.req_vaddr = reqVaddr;
   assign busLs.req_store = reqStore;
   assign busLs.rsp_ready = rspReady;
   assign busIf.req_valid = reqValid;
   assign busIf.req_vaddr = reqVaddr;
   assign busIf.req_store = reqStore;
   assign busIf.rsp_ready = rspReady;

   addr_trans #(.IS_FETCH(1'b0), .PALEN(32)) dutLs (
      .clk(clk), .resetn(resetn), .flush(flush), .bus(busLs),
      .crmd_da(crmdDa), .crmd_pg(crmdPg), .crmd_plv(crmdPlv), .da_mat(daMat),
      .asid(asid), .dmw0(dmw0), .dmw1(dmw1),
      .tlb_vppn(vppnLs), .tlb_va_bit12(bit12Ls), .tlb_asid(asidLs),
      .tlb_found(tlbFound), .tlb_d(tlbD), .tlb_v(tlbV), .tlb_ppn(tlbPpn),
      .tlb_ps(tlbPs), .tlb_plv(tlbPlv), .tlb_mat(tlbMat)
`ifdef ADDR_TRANS_STAT_EN
      , .stat_tlb_miss(statLs)
`endif
   );

   addr_trans #(.IS_FETCH(1'b1), .PALEN(32)) dutIf (
      .clk(clk), .resetn(resetn), .flush(flush), .bus(busIf),
      .crmd_da(crmdDa), .crmd_pg(crmdPg), .crmd_plv(crmdPlv), .da_mat(daMat),
      .asid(asid), .dmw0(dmw0), .dmw1(dmw1),
      .tlb_vppn(vppnIf), .tlb_va_bit12(bit12If), .tlb_asid(asidIf),
      .tlb_found(tlbFound), .tlb_d(tlbD), .tlb_v(tlbV), .tlb_ppn(tlbPpn),
      .tlb_ps(tlbPs), .tlb_plv(tlbPlv), .tlb_mat(tlbMat)
`ifdef ADDR_TRANS_STAT_EN
      , .stat_tlb_miss(statIf)
`endif
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic bit dmwHits(input logic [31:0] d, input logic [31:0] va);
      bit enabled;
      enabled = (crmdPlv == 0 && (d % 2) == 1) || (crmdPlv == 3 && ((d >> 3) % 2) == 1);
      return enabled && ((d >> 29) == (va >> 29));
   endfunction

   // Reference translation computed from the architectural rules with plain arithmetic.
   function automatic expT refModel(input bit isFetch, input logic [31:0] va, input logic st);
      expT e;
      bit  tlbMode;
      tlbMode = 0;
      e.badv  = va;
      if (crmdDa) begin
         e.paddr = va;
         e.mat   = daMat;
      end else if (dmwHits(dmw0, va)) begin
         e.paddr = (((dmw0 >> 25) % 8) << 29) + (va % 32'h2000_0000);
         e.mat   = (dmw0 >> 4) % 4;
      end else if (dmwHits(dmw1, va)) begin
         e.paddr = (((dmw1 >> 25) % 8) << 29) + (va % 32'h2000_0000);
         e.mat   = (dmw1 >> 4) % 4;
      end else begin
         tlbMode = 1;
         e.mat   = tlbMat;
         if (tlbPs == 22) e.paddr = (32'(tlbPpn) / 1024) * 32'h40_0000 + (va % 32'h40_0000);
         else             e.paddr = 32'(tlbPpn) * 4096 + (va % 4096);
      end
      if (isFetch && (va % 4) != 0)        e.ecode = 6'h08;
      else if (!tlbMode)                    e.ecode = 6'h00;
      else if (!tlbFound)                   e.ecode = 6'h3F;
      else if (!tlbV)                       e.ecode = isFetch ? 6'h03 : (st ? 6'h02 : 6'h01);
      else if (crmdPlv > tlbPlv)            e.ecode = 6'h07;
      else if (st && !tlbD)                 e.ecode = 6'h04;
      else                                  e.ecode = 6'h00;
      e.ex = (e.ecode != 0);
      return e;
   endfunction

   task automatic checkHead(input string pfx, input logic [31:0] paddr, input logic [1:0] mat,
                            input logic ex, input logic [5:0] ecode, input logic [31:0] badv, input expT e);
      checkOutput({pfx, "_ecode"}, ecode, e.ecode);
      checkOutput({pfx, "_ex"}, ex, e.ex);
      checkOutput({pfx, "_mat"}, mat, e.mat);
      checkOutput({pfx, "_badv"}, badv, e.badv);
      if (!e.ex) checkOutput({pfx, "_paddr"}, paddr, e.paddr);
   endtask

   // Presents the current input vector for one clock, checking outputs and advancing the model.
   task automatic applyStimulus();
      bit acceptNow;
      bit popNow;
      expT eLs, eIf;
      #1;
      checkOutput("req_ready_ls", busLs.req_ready, (qLs.size() < 2) && !flush);
      checkOutput("req_ready_if", busIf.req_ready, (qIf.size() < 2) && !flush);
      checkOutput("rsp_valid_ls", busLs.rsp_valid, qLs.size() != 0);
      checkOutput("rsp_valid_if", busIf.rsp_valid, qIf.size() != 0);
      checkOutput("tlb_vppn", vppnLs, reqVaddr >> 13);
      checkOutput("tlb_bit12", bit12If, (reqVaddr >> 12) % 2);
      checkOutput("tlb_asid", asidLs, asid);
      if (qLs.size() != 0)
         checkHead("ls", busLs.rsp_paddr, busLs.rsp_mat, busLs.rsp_ex, busLs.rsp_ecode, busLs.rsp_badv, qLs[0]);
      if (qIf.size() != 0)
         checkHead("if", busIf.rsp_paddr, busIf.rsp_mat, busIf.rsp_ex, busIf.rsp_ecode, busIf.rsp_badv, qIf[0]);
`ifdef ADDR_TRANS_STAT_EN
      checkOutput("stat_ls", statLs, statLsModel);
      checkOutput("stat_if", statIf, statIfModel);
`endif
      acceptNow = reqValid && (qLs.size() < 2) && !flush;
      popNow    = rspReady && (qLs.size() != 0) && !flush;
      if (flush) begin
         qLs.delete();
         qIf.delete();
      end else begin
         if (popNow) begin
            void'(qLs.pop_front());
            void'(qIf.pop_front());
         end
         if (acceptNow) begin
            eLs = refModel(1'b0, reqVaddr, reqStore);
            eIf = refModel(1'b1, reqVaddr, reqStore);
            qLs.push_back(eLs);
            qIf.push_back(eIf);
`ifdef ADDR_TRANS_STAT_EN
            if (eLs.ecode == 6'h3F) statLsModel++;
            if (eIf.ecode == 6'h3F) statIfModel++;
`endif
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic sendOne(input logic [31:0] va, input logic st);
      reqValid = 1'b1;
      reqVaddr = va;
      reqStore = st;
      rspReady = 1'b1;
      applyStimulus();
      reqValid = 1'b0;
   endtask

   task automatic expectLs(input string tag, input logic [31:0] paddr, input logic [1:0] mat, input logic [5:0] ecode);
      checkOutput({tag, "_valid"}, busLs.rsp_valid, 1'b1);
      checkOutput({tag, "_ecode"}, busLs.rsp_ecode, ecode);
      checkOutput({tag, "_mat"}, busLs.rsp_mat, mat);
      if (ecode == 6'h00) checkOutput({tag, "_paddr"}, busLs.rsp_paddr, paddr);
   endtask

   initial begin
      total = 0; bad = 0;
`ifdef ADDR_TRANS_STAT_EN
      statLsModel = 0; statIfModel = 0;
`endif
      resetn = 1'b0; flush = 1'b0;
      reqValid = 1'b0; reqVaddr = 32'h0; reqStore = 1'b0; rspReady = 1'b0;
      crmdDa = 1'b0; crmdPg = 1'b1; crmdPlv = 2'd0; daMat = 2'd0; asid = 10'h155;
      dmw0 = 32'h0; dmw1 = 32'h0;
      tlbFound = 1'b1; tlbD = 1'b1; tlbV = 1'b1; tlbPpn = 20'h0; tlbPs = 6'd12; tlbPlv = 2'd3; tlbMat = 2'd2;

      @(negedge clk); #1;
      checkOutput("rst_rsp_valid", busLs.rsp_valid, 1'b0);
      checkOutput("rst_req_ready", busLs.req_ready, 1'b1);
      checkOutput("rst_paddr", busLs.rsp_paddr, 32'h0);
      checkOutput("rst_mat", busLs.rsp_mat, 2'd0);
      checkOutput("rst_ex", busLs.rsp_ex, 1'b0);
      checkOutput("rst_ecode", busLs.rsp_ecode, 6'h0);
      checkOutput("rst_badv", busLs.rsp_badv, 32'h0);
      checkOutput("rst_if_valid", busIf.rsp_valid, 1'b0);
      @(negedge clk);
      resetn = 1'b1;

      crmdDa = 1'b1; daMat = 2'd1;
      sendOne(32'h1C00_0000, 1'b0);
      expectLs("da", 32'h1C00_0000, 2'd1, 6'h00);
      crmdDa = 1'b0; dmw0 = 32'h8000_0011; tlbPpn = 20'h12345;
      sendOne(32'h8000_1234, 1'b0);
      expectLs("dmw0", 32'h0000_1234, 2'd1, 6'h00);
      crmdPlv = 2'd3;
      sendOne(32'h8000_1234, 1'b0);
      expectLs("dmw_plv3", 32'h1234_5234, 2'd2, 6'h00);
      crmdPlv = 2'd0;
      sendOne(32'h0040_3ABC, 1'b0);
      expectLs("tlb4k", 32'h1234_5ABC, 2'd2, 6'h00);
      tlbPs = 6'd22; tlbPpn = 20'hABCDE;
      sendOne(32'h0071_2345, 1'b0);
      expectLs("tlb4m", 32'hABF1_2345, 2'd2, 6'h00);
      tlbFound = 1'b0;
      sendOne(32'h0000_1000, 1'b0);
      expectLs("tlbr", 32'h0, 2'd2, 6'h3F);
      tlbFound = 1'b1; tlbD = 1'b0; tlbPlv = 2'd0;
      sendOne(32'h0000_2000, 1'b1);
      expectLs("pme", 32'h0, 2'd2, 6'h04);
      tlbD = 1'b1; crmdPlv = 2'd3;
      sendOne(32'h0000_3000, 1'b0);
      expectLs("ppi", 32'h0, 2'd2, 6'h07);
      crmdPlv = 2'd0; tlbV = 1'b0;
      sendOne(32'h0000_4000, 1'b1);
      expectLs("pis", 32'h0, 2'd2, 6'h02);
      checkOutput("pif_ecode", busIf.rsp_ecode, 6'h03);
      tlbV = 1'b1; tlbFound = 1'b0;
      sendOne(32'h0000_1002, 1'b0);
      checkOutput("adef_ecode", busIf.rsp_ecode, 6'h08);
      checkOutput("adef_ex", busIf.rsp_ex, 1'b1);
      expectLs("ls_tlbr", 32'h0, 2'd2, 6'h3F);
      tlbFound = 1'b1;

      // Backpressure: two accepts fill the queue, the third request must wait.
      rspReady = 1'b1; applyStimulus();
      rspReady = 1'b0; reqValid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         reqVaddr = 32'h0010_0000 + 32'(i) * 32'h100;
         if (i == 2) begin
            #1 checkOutput("bp_ready_low", busLs.req_ready, 1'b0);
         end
         applyStimulus();
      end
      rspReady = 1'b1;
      for (int i = 0; i < 4; i++) begin
         reqVaddr = 32'h0020_0000 + 32'(i) * 32'h100;
         applyStimulus();
      end
      checkOutput("pushpop_valid", busLs.rsp_valid, 1'b1);
      checkOutput("pushpop_ready", busLs.req_ready, 1'b1);

      // Flush with two queued entries, including refill misses for the stat counter.
      reqValid = 1'b0; applyStimulus();
      rspReady = 1'b0; reqValid = 1'b1; tlbFound = 1'b0;
      for (int i = 0; i < 2; i++) begin
         reqVaddr = 32'h0030_0000 + 32'(i) * 32'h40;
         applyStimulus();
      end
      flush = 1'b1; rspReady = 1'b1;
      #1 checkOutput("flush_ready", busLs.req_ready, 1'b0);
      applyStimulus();
      flush = 1'b0; reqValid = 1'b0; tlbFound = 1'b1;
      checkOutput("flush_empty", busLs.rsp_valid, 1'b0);
      applyStimulus();

      for (int i = 0; i < 400; i++) begin
         reqValid = ($urandom_range(0, 9) < 7);
         rspReady = ($urandom_range(0, 9) < 6);
         flush    = ($urandom_range(0, 19) == 0);
         reqVaddr = $urandom;
         if ($urandom_range(0, 1) == 1) reqVaddr[1:0] = 2'b00;
         reqStore = $urandom_range(0, 1);
         crmdDa   = ($urandom_range(0, 7) == 0);
         crmdPlv  = $urandom_range(0, 3);
         daMat    = $urandom_range(0, 3);
         asid     = $urandom_range(0, 1023);
         dmw0     = $urandom;
         dmw1     = $urandom;
         if ($urandom_range(0, 1) == 1) dmw0[31:29] = reqVaddr[31:29];
         if ($urandom_range(0, 1) == 1) dmw1[31:29] = reqVaddr[31:29];
         tlbFound = ($urandom_range(0, 5) != 0);
         tlbV     = ($urandom_range(0, 5) != 0);
         tlbD     = $urandom_range(0, 1);
         tlbPpn   = $urandom_range(0, 20'hFFFFF);
         tlbPs    = ($urandom_range(0, 1) == 1) ? 6'd22 : 6'd12;
         tlbPlv   = $urandom_range(0, 3);
         tlbMat   = $urandom_range(0, 3);
         applyStimulus();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/addr_trans.md
Name: addr_trans

Overview:
- Virtual-to-physical translation stage directly upstream of the TLB. It drives TLB search port 0 (fetch instance) or port 1 (load/store instance).
- Combines the TLB hit data with CRMD and DMW state to produce the physical address, MAT and exception code.
- Results are buffered in a 2-entry output queue with valid/ready on both sides. The pipeline consumes the queue output.

Parameters:
- IS_FETCH, 0, 1: instance serves IF (misalignment raises ADEF); 0: instance serves load/store.
- PALEN, 32, physical address width.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- flush  in  1  kill all buffered results; no accept this cycle
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_vaddr  in  32  virtual address
- req_store  in  1  1 = store access
- crmd_da, crmd_pg  in  1 each  direct / paged mode
- crmd_plv  in  2  current privilege
- da_mat  in  2  MAT used in DA mode
- asid  in  10  CSR ASID
- dmw0, dmw1  in  32 each  DMW CSRs
- tlb_vppn  out  19  = req_vaddr[31:13]
- tlb_va_bit12  out  1  = req_vaddr[12]
- tlb_asid  out  10  = asid
- tlb_found, tlb_d, tlb_v  in  1 each  TLB lookup result
- tlb_ppn  in  20  TLB lookup result
- tlb_ps  in  6  TLB lookup result
- tlb_plv, tlb_mat  in  2 each  TLB lookup result
- rsp_valid  out  1  head entry valid
- rsp_ready  in  1  consumer accepts head
- rsp_paddr  out  PALEN  physical address
- rsp_mat  out  2  memory access type
- rsp_ex  out  1  exception flag
- rsp_ecode  out  6  LoongArch ecode
- rsp_badv  out  32  faulting vaddr (= request vaddr)

Behaviour:
- Reset: queue empty; rsp_valid=0; req_ready=1; all rsp_* data outputs = 0.
- TLB outputs are purely combinational from req_vaddr/asid; the TLB responds in the same cycle.
- Translation is computed combinationally in the accept cycle and written to the queue tail. Latency from accept to rsp_valid is 1 cycle.
- Queue depth is 2, with a count of 0..2 and 1-bit head/tail pointers that wrap.
  - req_ready = (count!=2) & ~flush.
  - req_ready is independent of rsp_ready.
- Push and pop in the same cycle: count is unchanged. At count 2 no push can occur.
- flush: count←0 next cycle. An accept in the flush cycle is impossible (req_ready=0). A pop in the flush cycle is ignored.
- Mode select, in priority order:
  - crmd_da=1: paddr=vaddr, mat=da_mat.
  - Else, DMW hit. DMWn hits if vaddr[31:29]==dmwn[31:29] and the PLV enable bit matches: dmwn[0] for plv 0, dmwn[3] for plv 3; plv 1/2 never hits. On hit, paddr={dmwn[27:25], vaddr[28:0]} and mat=dmwn[5:4]. DMW0 wins when both hit.
  - Else, TLB. With ps==12, paddr={tlb_ppn, vaddr[11:0]}. With ps==22, paddr={tlb_ppn[19:10], vaddr[21:0]}. mat=tlb_mat.
- Exceptions, in priority order; the first one that applies is taken:
  1. IS_FETCH and vaddr[1:0]!=0: ADEF, ecode 0x08.
  2. TLB mode and !tlb_found: TLBR, ecode 0x3F.
  3. !tlb_v: PIF 0x03 if IS_FETCH; else PIS 0x02 if store; else PIL 0x01.
  4. crmd_plv > tlb_plv: PPI, ecode 0x07.
  5. Store and !tlb_d: PME, ecode 0x04.
  - No exception: rsp_ex=0 and ecode=0.
  - On exception the paddr field is still written but is don't-care.
- Exceptions from rules 2-5 occur only in TLB mode. DA and DMW accesses raise only ADEF.
- CSR inputs are sampled only in the accept cycle. Later CSR changes do not alter entries already in the queue.

Optional Feature:
- Macro ADDR_TRANS_STAT_EN.
- When defined, adds output stat_tlb_miss[31:0]. The counter is reset to 0 and increments on every accepted request whose ecode is 0x3F. It saturates at 0xFFFFFFFF and is not cleared by flush.
- When undefined, the port and the counter are absent.

Decomposition:
- Shared package trans_pkg holds:
  - ecode constants: ECODE_TLBR, ECODE_PIL, ECODE_PIS, ECODE_PIF, ECODE_PME, ECODE_PPI, ECODE_ADE.
  - PS constants PS_4K=12 and PS_4M=22.
  - DMW field bit positions.
- One sub-module, trans_queue2: a 2-entry FIFO with push/pop/flush and count, parameterised by entry width.
- Translation and exception logic stays combinational in addr_trans.

Test Plan:
- DA mode: da=1, da_mat=1, vaddr 0x1C000000 → next cycle rsp paddr 0x1C000000, mat 1, ex 0.
- DMW: pg=1, plv0, dmw0=0x80000011, vaddr 0x80001234 → paddr 0x00001234, mat 1, no exception. Repeat with plv3 → falls through to TLB.
- TLB 4K/4M: ps=12, ppn 0x12345, vaddr 0x00403ABC → paddr 0x12345ABC. Then ps=22, ppn 0xABCDE, vaddr 0x00712345 → paddr 0xABF12345.
- Exception priority: load with found=0 → TLBR 0x3F. Store with v=1, d=0, plv0 → PME 0x04. plv3 vs tlb_plv 0 → PPI 0x07. Fetch vaddr 0x...2 → ADEF 0x08 regardless of TLB.
- Backpressure: rsp_ready=0 with 3 requests → req_ready drops after 2 accepts. Release → in-order drain, with push+pop in the same cycle holding count at 1.
- Flush with 2 entries queued → rsp_valid=0 next cycle and req_ready=0 in the flush cycle. With ADDR_TRANS_STAT_EN: 3 misses → stat_tlb_miss=3, unchanged after flush.
